// File: rtl/fp_pkg.sv
// Shared floating-point definitions: round-mode encodings, flag bit positions and format constants.
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE     = 2'b00,
        RM_RTZ     = 2'b01,
        RM_RMM     = 2'b10,
        RM_RNE_ALT = 2'b11
    } rm_e;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;
    localparam int FLAG_DZ = 4;

    localparam int EMAX_SP   = 254;
    localparam int EMAX_HP   = 30;
    localparam int HP_REBIAS = 112;

    localparam logic [31:0] CANON_NAN_SP = 32'h7FC00000;
    localparam logic [15:0] CANON_NAN_HP = 16'h7E00;

    function automatic logic [4:0] mk_flags(input logic of, input logic uf, input logic nx);
        logic [4:0] f;
        f          = '0;
        f[FLAG_NX] = nx;
        f[FLAG_UF] = uf;
        f[FLAG_OF] = of;
        f[FLAG_NV] = 1'b0;
        f[FLAG_DZ] = 1'b0;
        return f;
    endfunction

    // Special results are only NaN/inf/zero; anything else collapses to a signed zero.
    function automatic logic [15:0] sp_special_to_hp(input logic [31:0] r);
        logic [15:0] h;
        if (r[30:23] == CANON_NAN_SP[30:23] && r[22:0] != 23'h0) begin
            h = CANON_NAN_HP;
        end else if (r[30:23] == CANON_NAN_SP[30:23]) begin
            h = {r[31], 5'h1F, 10'h000};
        end else begin
            h = {r[31], 15'h0000};
        end
        return h;
    endfunction

endpackage

// File: rtl/fp_mul_round_if.sv
// Upstream/downstream bundle of the multiplier rounding stage; slave = the rounding block.
interface fp_mul_round_if #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
);
    logic              valid_in;
    logic              ready_out;
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_in;
    logic              precision_mode;
    logic [1:0]        round_mode;
    logic              spec_override;
    logic [31:0]       spec_result;
    logic [4:0]        spec_flags;
    logic              valid_out;
    logic              ready_in;
    logic [31:0]       result;
    logic [4:0]        flags;

    modport master (
        output valid_in, sign_in, exp_in, mant_in, precision_mode, round_mode,
               spec_override, spec_result, spec_flags, ready_in,
        input  ready_out, valid_out, result, flags
    );

    modport slave (
        input  valid_in, sign_in, exp_in, mant_in, precision_mode, round_mode,
               spec_override, spec_result, spec_flags, ready_in,
        output ready_out, valid_out, result, flags
    );
endinterface

// File: rtl/fp_round_inc.sv
// Round-increment of a truncated mantissa from guard/sticky/LSB and mode; reports carry-out.
// FP_MUL_ROUND_RMM_EN adds ties-away for RM_RMM; without it RM_RMM rounds as RNE.
module fp_round_inc
    import fp_pkg::*;
#(
    parameter int W = 23
) (
    input  logic [W-1:0] i_keep,
    input  logic         i_g,
    input  logic         i_s,
    input  rm_e          i_rm,
    output logic [W-1:0] o_keep,
    output logic         o_carry,
    output logic         o_inexact
);

    logic w_inc;

    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RTZ:  w_inc = 1'b0;
`ifdef FP_MUL_ROUND_RMM_EN
            RM_RMM:  w_inc = i_g;
`endif
            default: w_inc = i_g && (i_s || i_keep[0]);
        endcase
    end

    assign {o_carry, o_keep} = {1'b0, i_keep} + {{W{1'b0}}, w_inc};
    assign o_inexact         = i_g | i_s;

endmodule

// File: rtl/fp_mul_round.sv
// Round/pack stage of the FP multiplier: stage A rounds, stage B classifies and packs; 2-cycle latency.
// Optional macro FP_MUL_ROUND_RMM_EN enables ties-away rounding; each stage stalls only when full and blocked.
module fp_mul_round
    import fp_pkg::*;
#(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mul_round_if.slave bus
);

    localparam int E_W = EXP_W + 1;

    typedef struct packed {
        logic                  sign;
        logic signed [E_W-1:0] e;
        logic [22:0]           keep;
        logic                  inexact;
        logic                  prec;
        rm_e                   rm;
        logic                  ovr;
        logic [31:0]           sres;
        logic [4:0]            sflg;
    } stage_a_t;

    logic                  w_unused_msb;
    rm_e                   w_rm_in;
    logic [22:0]           w_keep_sp;
    logic [9:0]            w_keep_hp;
    logic                  w_cy_sp;
    logic                  w_cy_hp;
    logic                  w_nx_sp;
    logic                  w_nx_hp;
    logic signed [E_W-1:0] w_e_sp;
    logic signed [E_W-1:0] w_e_hp;
    logic signed [E_W-1:0] w_e_b;
    logic signed [E_W-1:0] w_emax;
    stage_a_t              w_a_nxt;
    logic [31:0]           w_res;
    logic [4:0]            w_flg;
    logic                  w_rdy_a;
    logic                  w_rdy_b;

    stage_a_t              r_a;
    logic                  r_a_vld;
    logic                  r_b_vld;
    logic [31:0]           r_result;
    logic [4:0]            r_flags;

    assign w_unused_msb = bus.mant_in[MANT_W-1];
    assign w_rm_in      = rm_e'(bus.round_mode);

    fp_round_inc #(.W(23)) u_inc_sp (
        .i_keep    (bus.mant_in[45:23]),
        .i_g       (bus.mant_in[22]),
        .i_s       (|bus.mant_in[21:0]),
        .i_rm      (w_rm_in),
        .o_keep    (w_keep_sp),
        .o_carry   (w_cy_sp),
        .o_inexact (w_nx_sp)
    );

    fp_round_inc #(.W(10)) u_inc_hp (
        .i_keep    (bus.mant_in[45:36]),
        .i_g       (bus.mant_in[35]),
        .i_s       (|bus.mant_in[34:0]),
        .i_rm      (w_rm_in),
        .o_keep    (w_keep_hp),
        .o_carry   (w_cy_hp),
        .o_inexact (w_nx_hp)
    );

    assign w_e_sp = E_W'(signed'(bus.exp_in));
    assign w_e_hp = w_e_sp - E_W'(HP_REBIAS);

    always_comb begin
        w_a_nxt      = '0;
        w_a_nxt.sign = bus.sign_in;
        w_a_nxt.prec = bus.precision_mode;
        w_a_nxt.rm   = w_rm_in;
        w_a_nxt.ovr  = bus.spec_override;
        w_a_nxt.sres = bus.spec_result;
        w_a_nxt.sflg = bus.spec_flags;
        if (bus.precision_mode) begin
            w_a_nxt.e       = w_e_hp + {{(E_W-1){1'b0}}, w_cy_hp};
            w_a_nxt.keep    = {13'h0, w_keep_hp};
            w_a_nxt.inexact = w_nx_hp;
        end else begin
            w_a_nxt.e       = w_e_sp + {{(E_W-1){1'b0}}, w_cy_sp};
            w_a_nxt.keep    = w_keep_sp;
            w_a_nxt.inexact = w_nx_sp;
        end
    end

    assign w_e_b  = r_a.e;
    assign w_emax = r_a.prec ? E_W'(EMAX_HP) : E_W'(EMAX_SP);

    always_comb begin
        w_res = '0;
        w_flg = '0;
        if (r_a.ovr) begin
            w_res = r_a.prec ? {16'h0, sp_special_to_hp(r_a.sres)} : r_a.sres;
            w_flg = r_a.sflg;
        end else if (w_e_b > w_emax) begin
            // Truncating toward zero never reaches infinity; saturate to max finite instead.
            if (r_a.rm == RM_RTZ) begin
                w_res = r_a.prec ? {16'h0, r_a.sign, 5'h1E, 10'h3FF}
                                 : {r_a.sign, 8'hFE, 23'h7FFFFF};
            end else begin
                w_res = r_a.prec ? {16'h0, r_a.sign, 5'h1F, 10'h000}
                                 : {r_a.sign, 8'hFF, 23'h000000};
            end
            w_flg = mk_flags(1'b1, 1'b0, 1'b1);
        end else if (w_e_b <= E_W'(0)) begin
            w_res = r_a.prec ? {16'h0, r_a.sign, 15'h0000} : {r_a.sign, 31'h0};
            w_flg = mk_flags(1'b0, 1'b1, 1'b1);
        end else begin
            w_res = r_a.prec ? {16'h0, r_a.sign, w_e_b[4:0], r_a.keep[9:0]}
                             : {r_a.sign, w_e_b[7:0], r_a.keep};
            w_flg = mk_flags(1'b0, 1'b0, r_a.inexact);
        end
    end

    assign w_rdy_b       = !r_b_vld || bus.ready_in;
    assign w_rdy_a       = !r_a_vld || w_rdy_b;
    assign bus.ready_out = w_rdy_a;
    assign bus.valid_out = r_b_vld;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_vld  <= 1'b0;
            r_a      <= '0;
            r_b_vld  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_rdy_a) begin
                r_a_vld <= bus.valid_in;
                if (bus.valid_in) begin
                    r_a <= w_a_nxt;
                end
            end
            if (w_rdy_b) begin
                r_b_vld <= r_a_vld;
                if (r_a_vld) begin
                    r_result <= w_res;
                    r_flags  <= w_flg;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_round.sv
// Directed bench for fp_mul_round: rounding, overflow/underflow, binary16, override, backpressure, reset.
module tb_fp_mul_round;
    import fp_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    fp_mul_round_if #(.MANT_W(48), .EXP_W(10)) bus ();

    fp_mul_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m, input logic p,
                         input logic [1:0] rm, input logic ov, input logic [31:0] sr, input logic [4:0] sf);
        bus.valid_in       = 1'b1;
        bus.sign_in        = s;
        bus.exp_in         = e;
        bus.mant_in        = m;
        bus.precision_mode = p;
        bus.round_mode     = rm;
        bus.spec_override  = ov;
        bus.spec_result    = sr;
        bus.spec_flags     = sf;
    endtask

    // One beat through an idle pipe; mode inputs are scrambled right after accept.
    task automatic run(input string tag, input logic s, input logic [9:0] e, input logic [47:0] m,
                       input logic p, input logic [1:0] rm, input logic ov, input logic [31:0] sr,
                       input logic [4:0] sf, input logic [31:0] xr, input logic [4:0] xf);
        @(negedge clk);
        drive(s, e, m, p, rm, ov, sr, sf);
        chk({tag, "/rdy"}, 32'(bus.ready_out), 32'd1);
        @(negedge clk);
        bus.valid_in       = 1'b0;
        bus.round_mode     = ~rm;
        bus.precision_mode = ~p;
        bus.spec_override  = ~ov;
        bus.mant_in        = ~m;
        chk({tag, "/vld1"}, 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        chk({tag, "/vld2"}, 32'(bus.valid_out), 32'd1);
        chk({tag, "/res"}, bus.result, xr);
        chk({tag, "/flg"}, 32'(bus.flags), 32'(xf));
    endtask

    initial begin
        logic [31:0] rmm_res;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.ready_in = 1'b1;
        drive(1'b0, 10'd0, 48'h0, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0);
        bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/valid_out", 32'(bus.valid_out), 32'd0);
        chk("reset/result", bus.result, 32'h0);
        chk("reset/flags", 32'(bus.flags), 32'd0);
        rst_n = 1'b1;

        run("sp_exact",   1'b0, 10'd128, 48'h4800_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h40100000, 5'b00000);
        run("rne_tie_ev", 1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h3F800000, 5'b00001);
        run("rne_tie_od", 1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h3F800002, 5'b00001);
        run("rm11_is_rne",1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 2'b11, 1'b0, 32'h0, 5'h0, 32'h3F800002, 5'b00001);
        run("carry_rne",  1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h40000000, 5'b00001);
        run("carry_rtz",  1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 1'b0, 2'b01, 1'b0, 32'h0, 5'h0, 32'h3FFFFFFF, 5'b00001);
        run("ovf_rne",    1'b0, 10'd255, 48'h4000_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h7F800000, 5'b00101);
        run("ovf_rtz",    1'b0, 10'd255, 48'h4000_0000_0000, 1'b0, 2'b01, 1'b0, 32'h0, 5'h0, 32'h7F7FFFFF, 5'b00101);
        run("emax_sp",    1'b0, 10'd254, 48'h4000_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h7F000000, 5'b00000);
        run("carry_ovf",  1'b1, 10'd254, 48'h7FFF_FFFF_FFFF, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'hFF800000, 5'b00101);
        run("unf_sp",     1'b1, 10'd0,   48'h4000_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h80000000, 5'b00011);
        run("unf_neg",    1'b0, 10'h3F0, 48'h4000_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h00000000, 5'b00011);
        run("unf_rescue", 1'b0, 10'd0,   48'h7FFF_FFFF_FFFF, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0, 32'h00800000, 5'b00001);
        run("hp_one",     1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 2'b00, 1'b0, 32'h0, 5'h0, 32'h00003C00, 5'b00000);
        run("hp_emax",    1'b0, 10'd142, 48'h4000_0000_0000, 1'b1, 2'b00, 1'b0, 32'h0, 5'h0, 32'h00007800, 5'b00000);
        run("hp_carryovf",1'b0, 10'd142, 48'h7FFF_FFFF_FFFF, 1'b1, 2'b00, 1'b0, 32'h0, 5'h0, 32'h00007C00, 5'b00101);
        run("hp_ovf_rtz", 1'b1, 10'd143, 48'h4000_0000_0000, 1'b1, 2'b01, 1'b0, 32'h0, 5'h0, 32'h0000FBFF, 5'b00101);
        run("hp_unf",     1'b1, 10'd112, 48'h4000_0000_0000, 1'b1, 2'b00, 1'b0, 32'h0, 5'h0, 32'h00008000, 5'b00011);
        run("hp_tie_rne", 1'b0, 10'd127, 48'h4008_0000_0000, 1'b1, 2'b00, 1'b0, 32'h0, 5'h0, 32'h00003C00, 5'b00001);
        run("ovr_hp_nan", 1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 2'b00, 1'b1, 32'h7FC00000, 5'b01000, 32'h00007E00, 5'b01000);
        run("ovr_hp_inf", 1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 2'b00, 1'b1, 32'hFF800000, 5'b00000, 32'h0000FC00, 5'b00000);
        run("ovr_hp_zero",1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 2'b00, 1'b1, 32'h80000000, 5'b00000, 32'h00008000, 5'b00000);
        run("ovr_sp",     1'b0, 10'd255, 48'h4000_0000_0000, 1'b0, 2'b01, 1'b1, 32'h7FC00000, 5'b01000, 32'h7FC00000, 5'b01000);
`ifdef FP_MUL_ROUND_RMM_EN
        rmm_res = 32'h3F800001;
`else
        rmm_res = 32'h3F800000;
`endif
        run("rm10_tie",   1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 2'b10, 1'b0, 32'h0, 5'h0, rmm_res, 5'b00001);

        // Backpressure: three beats offered with the sink stalled.
        @(negedge clk);
        bus.ready_in = 1'b0;
        drive(1'b0, 10'd128, 48'h4800_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0);
        chk("bp/rdy0", 32'(bus.ready_out), 32'd1);
        @(negedge clk);
        drive(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0);
        chk("bp/rdy1", 32'(bus.ready_out), 32'd1);
        @(negedge clk);
        drive(1'b0, 10'd129, 48'h4000_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0);
        chk("bp/rdy2", 32'(bus.ready_out), 32'd0);
        chk("bp/vld_hold", 32'(bus.valid_out), 32'd1);
        chk("bp/res_b0", bus.result, 32'h40100000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp/rdy_stall", 32'(bus.ready_out), 32'd0);
            chk("bp/res_stable", bus.result, 32'h40100000);
            chk("bp/vld_stable", 32'(bus.valid_out), 32'd1);
        end
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        chk("bp/vld_b1", 32'(bus.valid_out), 32'd1);
        chk("bp/res_b1", bus.result, 32'h3F800000);
        @(negedge clk);
        chk("bp/vld_b2", 32'(bus.valid_out), 32'd1);
        chk("bp/res_b2", bus.result, 32'h40800000);
        @(negedge clk);
        chk("bp/drained", 32'(bus.valid_out), 32'd0);

        // Reset with both stages occupied drops everything.
        @(negedge clk);
        drive(1'b0, 10'd128, 48'h4800_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0);
        @(negedge clk);
        drive(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 5'h0);
        @(negedge clk);
        bus.valid_in = 1'b0;
        chk("mid/vld_before", 32'(bus.valid_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid/vld_rst", 32'(bus.valid_out), 32'd0);
        chk("mid/res_rst", bus.result, 32'h0);
        chk("mid/flg_rst", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid/no_ghost", 32'(bus.valid_out), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_mul_round.md
Name: fp_mul_round

Overview:
- Rounding and packing stage of the floating-point multiplier pipeline. It sits directly downstream of the normalisation stage and replaces the truncating pack stage.
- Consumes the sign, a widened biased exponent, the 48-bit normalised product and the special-case override bundle.
- Applies the IEEE rounding mode, detects overflow and underflow, re-encodes to binary32 or binary16, and raises exception flags.
- Two-stage valid/ready pipeline.

Parameters:
- MANT_W, 48, product mantissa width; the leading one is at bit 46.
- EXP_W, 10, signed biased exponent input width (two's complement).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  upstream beat valid
- ready_out  out  1  this block can accept a beat
- sign_in  in  1  product sign
- exp_in  in  EXP_W  signed, binary32-biased exponent
- mant_in  in  MANT_W  normalised product, bit47 = 0
- precision_mode  in  1  1 = binary16, 0 = binary32
- round_mode  in  2  00 = RNE, 01 = RTZ, 10 = RMM (see feature), 11 = RNE
- spec_override  in  1  use spec_result instead of the computed result
- spec_result  in  32  binary32-encoded special result
- spec_flags  in  5  flags for the special result
- valid_out  out  1  result valid
- ready_in  in  1  downstream ready
- result  out  32  packed result; binary16 in [15:0] with [31:16] = 0
- flags  out  5  {DZ, NV, OF, UF, NX}; DZ is always 0

Behaviour:
- Reset: valid_out = 0 and every internal valid = 0; result, flags and all pipeline registers = 0.
- Handshake, per stage: ready = !valid || downstream_ready.
  - Accept when valid_in && ready_out.
  - Output is held stable while valid_out && !ready_in.
  - Throughput is 1 beat/cycle with no bubbles when ready_in = 1. Latency is 2 cycles from accept to valid_out.
- Stage A (round):
  - binary32 fields: keep = mant_in[45:23], G = mant_in[22], S = |mant_in[21:0].
  - binary16 fields: keep = mant_in[45:36], G = mant_in[35], S = |mant_in[34:0]; exponent is rebiased, e = exp_in − 112.
  - Increment rule:
    - RNE: G && (S || keep[0]).
    - RTZ: never.
    - RMM: G.
  - inexact = G || S.
  - If the increment carries out of keep, set keep to 0 and add 1 to e.
  - Register {sign, e, keep, inexact, precision_mode, round_mode, spec bundle}.
- Stage B (classify and pack); EMAX = 254 for binary32, 30 for binary16:
  - spec_override = 1: result = spec_result (binary32) and flags = spec_flags.
    - binary16 mapping: NaN → 16'h7E00; inf → {s, 5'h1F, 10'h0}; zero → {s, 15'h0}.
  - e > EMAX: overflow. Result is inf for RNE/RMM and max finite for RTZ; flags = OF|NX (5'b00101).
  - e <= 0: flush to signed zero; flags = UF|NX (5'b00011). No subnormal output.
  - Otherwise: pack {sign, e[7:0] or e[4:0], keep}; flags = NX if inexact, else 0.
- Boundaries:
  - Carry-out that pushes e above EMAX takes the overflow path.
  - e = EMAX exactly packs normally.
  - round_mode and precision_mode are sampled only at accept.
  - Reset mid-flight drops all in-flight beats.

Optional Feature:
- Macro FP_MUL_ROUND_RMM_EN.
- Defined: round_mode 2'b10 selects round-to-nearest, ties-away.
- Undefined: 2'b10 is treated as RNE, and the RMM increment logic is not synthesised.

Decomposition:
- Shared package fp_pkg holds:
  - Round-mode encodings: RM_RNE, RM_RTZ, RM_RMM.
  - Flag bit indices: FLAG_NX = 0, FLAG_UF = 1, FLAG_OF = 2, FLAG_NV = 3, FLAG_DZ = 4.
  - Constants: EMAX_SP = 254, EMAX_HP = 30, HP_REBIAS = 112, CANON_NAN_SP = 32'h7FC00000, CANON_NAN_HP = 16'h7E00.
- One sub-module, fp_round_inc: combinational G/S/keep → increment and carry. It is reused for both precisions.
- The pipeline register slice is coded inline.

Test Plan:
- binary32 exact, RNE: exp_in = 128, mant_in = 48'h4800_0000_0000 → result 32'h40100000, flags 0, valid_out 2 cycles after accept.
- RNE ties: exp_in = 127 with mant_in = 48'h4000_0040_0000 → 32'h3F800000, NX. With mant_in = 48'h4000_00C0_0000 → 32'h3F800002, NX.
- Carry-out: exp_in = 127, mant_in = 48'h7FFF_FFFF_FFFF. RNE → 32'h40000000, NX. RTZ → 32'h3FFFFFFF, NX.
- Overflow and underflow:
  - exp_in = 255, mant_in = 48'h4000_0000_0000, RNE → 32'h7F800000, flags 5'b00101. RTZ → 32'h7F7FFFFF.
  - sign_in = 1, exp_in = 0 → 32'h80000000, flags 5'b00011.
- binary16 and override:
  - precision_mode = 1, exp_in = 127, mant_in = 48'h4000_0000_0000 → 32'h00003C00.
  - spec_override = 1 with spec_result = 32'h7FC00000, spec_flags = 5'b01000 → 32'h00007E00, flags 5'b01000.
- Backpressure: ready_in held at 0 while 3 beats are offered back-to-back.
  - Exactly 2 are accepted, then ready_out = 0.
  - Output is stable throughout.
  - Releasing ready_in delivers the beats in order with none lost or duplicated.
